// File: rtl/keyscan_buf.sv
// Debounced key scanner with priority encoder and a small FIFO of press codes.
// Define KEYSCAN_BUF_REPEAT_EN to add auto-repeat events while a key stays held.
module keyscan_buf #(
    parameter int NKEYS         = 16,
    parameter int DB_CYCLES     = 4,
    parameter int DEPTH         = 4,
    parameter int REPEAT_CYCLES = 8,
    localparam int VW           = $clog2(NKEYS),
    localparam int CW           = $clog2(DEPTH + 1)
) (
    input  logic             clock,
    input  logic             reset,
    input  logic [NKEYS-1:0] keys,
    output logic             key_in,
    output logic [VW-1:0]    key_val,
    output logic             code_valid,
    input  logic             code_ready,
    output logic [VW-1:0]    code,
    output logic [CW-1:0]    count,
    output logic             overflow
);

    localparam int DBW = (DB_CYCLES > 1) ? $clog2(DB_CYCLES) : 1;
    localparam int PW  = $clog2(DEPTH);

    logic [NKEYS-1:0] sync1_r;
    logic [NKEYS-1:0] sync2_r;
    logic [NKEYS-1:0] stable_r;
    logic [NKEYS-1:0] stable_prev_r;
    logic [DBW-1:0]   db_cnt_r;
    logic [VW-1:0]    mem_r [DEPTH];
    logic [PW-1:0]    wr_ptr_r;
    logic [PW-1:0]    rd_ptr_r;
    logic [CW-1:0]    count_r;
    logic             overflow_r;

    logic [VW-1:0]    key_val_s;
    logic             press_s;
    logic             event_s;
    logic             full_s;
    logic             push_s;
    logic             pop_s;

    // Two-flop synchronizer for the asynchronous key levels.
    always_ff @(posedge clock) begin
        if (reset) begin
            sync1_r <= '0;
            sync2_r <= '0;
        end else begin
            sync1_r <= keys;
            sync2_r <= sync1_r;
        end
    end

    // Debounce: commit sync2 to stable once it has differed for DB_CYCLES cycles;
    // a value about to change in sync2 restarts the window.
    always_ff @(posedge clock) begin
        if (reset) begin
            stable_r      <= '0;
            stable_prev_r <= '0;
            db_cnt_r      <= '0;
        end else begin
            stable_prev_r <= stable_r;
            if (sync2_r != stable_r) begin
                if (db_cnt_r == DBW'(DB_CYCLES - 1)) begin
                    stable_r <= sync2_r;
                    db_cnt_r <= '0;
                end else if (sync1_r != sync2_r) begin
                    db_cnt_r <= '0;
                end else begin
                    db_cnt_r <= db_cnt_r + 1'b1;
                end
            end else begin
                db_cnt_r <= '0;
            end
        end
    end

    // Priority encoder: the highest set index wins and maps to code NKEYS-1-i.
    always_comb begin
        key_val_s = '0;
        for (int i = 0; i < NKEYS; i++) begin
            key_val_s = stable_r[i] ? VW'(NKEYS - 1 - i) : key_val_s;
        end
    end

    assign press_s = (stable_prev_r == '0) && (stable_r != '0);

`ifdef KEYSCAN_BUF_REPEAT_EN
    localparam int RW = $clog2(REPEAT_CYCLES);

    logic [RW-1:0] rep_cnt_r;
    logic          rep_s;

    assign rep_s = (stable_r != '0) && (stable_r == stable_prev_r) &&
                   (rep_cnt_r == RW'(REPEAT_CYCLES - 1));

    // Repeat timer: cleared on any stable change and after each repeat, saturates when idle.
    always_ff @(posedge clock) begin
        if (reset) begin
            rep_cnt_r <= '0;
        end else if ((stable_r != stable_prev_r) || rep_s) begin
            rep_cnt_r <= '0;
        end else if (rep_cnt_r != RW'(REPEAT_CYCLES - 1)) begin
            rep_cnt_r <= rep_cnt_r + 1'b1;
        end else begin
            rep_cnt_r <= rep_cnt_r;
        end
    end

    assign event_s = press_s | rep_s;
`else
    assign event_s = press_s;
`endif

    assign full_s = (count_r == CW'(DEPTH));
    assign pop_s  = (count_r != '0) && code_ready;
    assign push_s = event_s && (!full_s || pop_s);

    // Code FIFO; pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clock) begin
        if (reset) begin
            wr_ptr_r   <= '0;
            rd_ptr_r   <= '0;
            count_r    <= '0;
            overflow_r <= 1'b0;
            for (int i = 0; i < DEPTH; i++) begin
                mem_r[i] <= '0;
            end
        end else begin
            if (push_s) begin
                mem_r[wr_ptr_r] <= key_val_s;
                wr_ptr_r        <= wr_ptr_r + 1'b1;
            end
            if (pop_s) begin
                rd_ptr_r <= rd_ptr_r + 1'b1;
            end
            if (push_s && !pop_s) begin
                count_r <= count_r + 1'b1;
            end else if (pop_s && !push_s) begin
                count_r <= count_r - 1'b1;
            end
            if (event_s && full_s && !pop_s) begin
                overflow_r <= 1'b1;
            end
        end
    end

    assign key_in     = |stable_r;
    assign key_val    = key_val_s;
    assign code_valid = (count_r != '0);
    assign code       = mem_r[rd_ptr_r];
    assign count      = count_r;
    assign overflow   = overflow_r;

endmodule

// File: doc/keyscan_buf.md
KEYSCAN_BUF -- requirements
Module: keyscan_buf

Interface
REQ-001 Parameter NKEYS, default 16, number of key inputs (2..64); VW = clog2(NKEYS) is the code width.
REQ-002 Parameter DB_CYCLES, default 4, debounce stability window in clock cycles (>=1).
REQ-003 Parameter DEPTH, default 4, code FIFO depth (power of 2, >=2).
REQ-004 Parameter REPEAT_CYCLES, default 8, auto-repeat period in cycles (>=2), used only under the configuration macro.
REQ-005 clock  input  1  single clock; all state updates on its rising edge.
REQ-006 reset  input  1  synchronous, active-high reset.
REQ-007 keys  input  NKEYS  raw asynchronous key levels, 1 = pressed.
REQ-008 key_in  output  1  1 when any debounced key is pressed.
REQ-009 key_val  output  VW  priority-encoded code of the debounced key vector.
REQ-010 code_valid  output  1  FIFO non-empty; code is valid.
REQ-011 code_ready  input  1  consumer accepts code this cycle.
REQ-012 code  output  VW  head-of-FIFO key code.
REQ-013 count  output  clog2(DEPTH+1)  current FIFO occupancy.
REQ-014 overflow  output  1  sticky flag: a key event was dropped.

Function
REQ-015 keys SHALL pass through a two-flop synchronizer before any other use.
REQ-016 The debounced vector (stable) SHALL take a new value exactly DB_CYCLES+2 rising edges after keys changes, provided keys holds for that whole period; shorter glitches SHALL leave stable unchanged.
REQ-017 key_in SHALL equal OR-reduction of stable, combinationally.
REQ-018 key_val SHALL be NKEYS-1-i for the highest set index i of stable (keys[NKEYS-1] -> 0, keys[0] -> NKEYS-1), and 0 when stable is all-zero (never X).
REQ-019 A press event SHALL occur in the cycle after stable changes from all-zero to non-zero; the event carries key_val at that cycle.
REQ-020 Changes of stable between two non-zero values, and releases, SHALL NOT create events.
REQ-021 An event SHALL be pushed into the FIFO when count < DEPTH, or when count = DEPTH and a pop occurs in the same cycle.
REQ-022 An event arriving when full without a simultaneous pop SHALL be dropped and SHALL set overflow; FIFO contents unchanged.
REQ-023 A pop SHALL occur when code_valid && code_ready; code_ready while empty SHALL have no effect.
REQ-024 Push into an empty FIFO SHALL raise code_valid on the next cycle (no bypass); simultaneous push and pop with count=1 SHALL keep count=1 and present the new code.
REQ-025 code SHALL remain stable while code_valid && !code_ready; FIFO order SHALL be first-in first-out with pointer wrap-around modulo DEPTH.
REQ-026 count SHALL change by +1 (push only), -1 (pop only) or 0 (both/neither) per cycle.

Reset
REQ-027 While reset is high at a clock edge, synchronizer, debounce counter, stable, FIFO pointers, count, overflow and repeat timer SHALL clear to 0.
REQ-028 Outputs after reset: key_in=0, key_val=0, code_valid=0, code=0, count=0, overflow=0.
REQ-029 Reset mid-debounce or with queued codes SHALL discard them; a key held through reset release SHALL produce one press event DB_CYCLES+2+1 cycles after release.

Configuration
REQ-030 Macro KEYSCAN_BUF_REPEAT_EN, when defined, SHALL add auto-repeat: while stable is non-zero and unchanged, a further event carrying key_val SHALL be generated every REPEAT_CYCLES cycles after the press event.
REQ-031 With KEYSCAN_BUF_REPEAT_EN, any change of stable SHALL restart the repeat timer; repeat events obey REQ-021/022.
REQ-032 Without KEYSCAN_BUF_REPEAT_EN, only press events (REQ-019) SHALL exist and no repeat timer SHALL be instantiated.

Verification
REQ-033 Reset, keys=16'h0000 held 20 cycles -> key_in=0, key_val=0, code_valid=0, count=0.
REQ-034 keys=16'h8000 held 10 cycles, code_ready=1 -> key_val=0 after 6 edges, exactly one code=0 popped, then release gives no event.
REQ-035 keys=16'h0001 for 3 cycles then 0 -> stable never changes, no event, code_valid stays 0.
REQ-036 keys=16'h951F pressed -> key_val=0 (bit15 wins); change to 16'h0010 while held -> key_val=11, no second event (macro undefined).
REQ-037 code_ready=0, five separate presses of 16'h0100 -> count=4, overflow=1, then four pops return 7,7,7,7 and count=0.
REQ-038 With KEYSCAN_BUF_REPEAT_EN, 16'h0002 held 40 cycles, code_ready=1 -> codes 14 at press event and every 8 cycles thereafter (5 total); reset mid-hold -> overflow=0, count=0.
